// File: rtl/cpu_instr_fetch_bridge.sv
// Instruction-fetch bridge: turns one 128-bit CPU fetch into four 32-bit request/grant memory
// reads, reassembles the beats, and acks once. A response timeout keeps a dead memory from hanging the CPU.
module cpu_instr_fetch_bridge #(
  parameter int unsigned MEM_AW          = 32,
  parameter int unsigned TIMEOUT         = 256,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read_valid,
  input  logic [32:0]       cpu_read_addr,
  output logic [127:0]      cpu_read_data,
  output logic              cpu_read_ack,
  output logic              fetch_err,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StResp, StGap} state_e;

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [2:0]        issued_q, issued_d;
  logic [2:0]        returned_q, returned_d;
  logic [2:0]        drain_q, drain_d, drain_rst;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [127:0]      data_q, data_d;
  logic              req_q, req_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic              grant;
  logic              take;
  logic [2:0]        pend;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    drain_d    = drain_q;
    tmo_d      = tmo_q;
    data_d     = data_q;
    req_d      = req_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    grant      = req_q & mem_gnt;
    take       = 1'b0;

    // Returns of an abandoned fetch are swallowed here, never written to data.
    if (state_q != StFetch && drain_q != 3'd0 && mem_rvalid) begin
      drain_d = drain_q - 3'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (cpu_read_valid && drain_q == 3'd0) begin
          base_d     = MEM_AW'({cpu_read_addr, 2'b00});
          addr_d     = base_d;
          issued_d   = 3'd0;
          returned_d = 3'd0;
          tmo_d      = '0;
          req_d      = 1'b1;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        take       = mem_rvalid && (returned_q < issued_q);
        issued_d   = issued_q + {2'b00, grant};
        returned_d = returned_q + {2'b00, take};
        if (take) begin
          data_d[{returned_q[1:0], 5'd0} +: 32] = mem_rdata;
        end
        // Timer is idle until the first grant, then runs every fetch cycle.
        if (grant || tmo_q != '0) begin
          tmo_d = tmo_q + TW'(1);
        end
        req_d  = (issued_d < 3'd4) && ((issued_d - returned_d) < 3'(MAX_OUTSTANDING));
        addr_d = base_q + MEM_AW'(issued_d);
        if (returned_d == 3'd4) begin
          state_d = StResp;
          ack_d   = 1'b1;
          req_d   = 1'b0;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          state_d = StResp;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          req_d   = 1'b0;
          data_d  = '0;
          drain_d = issued_d - returned_d;
        end
      end
      StResp:  state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Beats still in flight when reset hits must be drained afterwards, including
    // one granted on the reset edge itself.
    pend      = (state_q == StFetch) ? (issued_q + {2'b00, grant} - returned_q) : drain_q;
    drain_rst = (mem_rvalid && pend != 3'd0) ? (pend - 3'd1) : pend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      addr_q     <= '0;
      issued_q   <= 3'd0;
      returned_q <= 3'd0;
      drain_q    <= drain_rst;
      tmo_q      <= '0;
      data_q     <= '0;
      req_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      drain_q    <= drain_d;
      tmo_q      <= tmo_d;
      data_q     <= data_d;
      req_q      <= req_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign cpu_read_data = data_q;
  assign cpu_read_ack  = ack_q;
  assign fetch_err     = err_q;
  assign mem_req       = req_q;
  assign mem_addr      = addr_q;

endmodule

// File: tb/tb_cpu_instr_fetch_bridge.sv
// Bench for cpu_instr_fetch_bridge: a latency-programmable memory model plus a scoreboard of
// expected beat addresses and assembled instructions.
module tb_cpu_instr_fetch_bridge;

  localparam int unsigned AW   = 8;
  localparam int unsigned TMO  = 16;
  localparam int unsigned MAXO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_read_valid;
  logic [32:0]   cpu_read_addr;
  logic [127:0]  cpu_read_data;
  logic          cpu_read_ack;
  logic          fetch_err;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  cpu_instr_fetch_bridge #(
    .MEM_AW         (AW),
    .TIMEOUT        (TMO),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_read_valid(cpu_read_valid),
    .cpu_read_addr (cpu_read_addr),
    .cpu_read_data (cpu_read_data),
    .cpu_read_ack  (cpu_read_ack),
    .fetch_err     (fetch_err),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    int          due;
  } ret_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   mem [256];
  logic [AW-1:0] exp_addr_q [$];
  logic [127:0]  exp_data_q [$];
  logic          exp_err_q [$];
  ret_t          pend_q [$];
  int            cyc = 0;
  int            lat = 1;
  bit            rand_gnt = 1'b0;
  int            ret_budget = 1000000;
  int            rv_cnt = 0;
  int            deny_run = 0;

  // Memory model: decides each cycle's gnt/rvalid at the negedge before the edge that samples them.
  initial begin : mem_model
    ret_t          r;
    logic [AW-1:0] ea;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (pend_q.size() > 0 && ret_budget > 0) begin
        if (pend_q[0].due <= cyc) begin
          r          = pend_q.pop_front();
          mem_rvalid = 1'b1;
          mem_rdata  = r.data;
          ret_budget--;
          rv_cnt++;
        end
      end
      if (!rand_gnt || deny_run >= 2) mem_gnt = 1'b1;
      else mem_gnt = 1'($urandom_range(1, 0));
      deny_run = mem_gnt ? 0 : deny_run + 1;
      if (mem_req && mem_gnt) begin
        r.data = mem[mem_addr];
        r.due  = cyc + lat;
        pend_q.push_back(r);
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_bad++;
          $display("FAIL grant_addr: grant at mem_addr %0d, required no request", mem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (mem_addr !== ea) begin
            n_bad++;
            $display("FAIL grant_addr: mem_addr %0d, required %0d", mem_addr, ea);
          end
        end
        n_cmp++;
        if (pend_q.size() > MAXO) begin
          n_bad++;
          $display("FAIL outstanding: %0d beats outstanding, required <= %0d", pend_q.size(), MAXO);
        end
      end
    end
  end

  task automatic start_fetch(input logic [32:0] a, input bit err, input bit fixed,
                             input logic [127:0] fixed_data);
    logic [AW-1:0] b;
    logic [127:0]  e;
    b = AW'({a, 2'b00});
    e = '0;
    for (int k = 0; k < 4; k++) begin
      exp_addr_q.push_back(AW'(b + AW'(k)));
      e[32*k +: 32] = mem[AW'(b + AW'(k))];
    end
    if (fixed) e = fixed_data;
    if (err) e = '0;
    exp_data_q.push_back(e);
    exp_err_q.push_back(err);
    rv_cnt         = 0;
    cpu_read_addr  = a;
    cpu_read_valid = 1'b1;
  endtask

  task automatic wait_ack(input string name, input int exp_lat, input int exp_rv);
    int           n;
    bit           seen;
    logic [127:0] ed;
    logic         ee;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = cpu_read_ack;
    end
    cpu_read_valid = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s_ack: no ack after %0d cycles, required an ack", name, n);
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_err_q.delete();
      return;
    end
    ed = exp_data_q.pop_front();
    ee = exp_err_q.pop_front();
    n_cmp++;
    if (cpu_read_data !== ed) begin
      n_bad++;
      $display("FAIL %s_data: got %h, required %h", name, cpu_read_data, ed);
    end
    n_cmp++;
    if (fetch_err !== ee) begin
      n_bad++;
      $display("FAIL %s_err: fetch_err %b, required %b", name, fetch_err, ee);
    end
    if (exp_lat >= 0) begin
      n_cmp++;
      if (n != exp_lat) begin
        n_bad++;
        $display("FAIL %s_latency: ack after %0d cycles, required %0d", name, n, exp_lat);
      end
    end
    if (exp_rv >= 0) begin
      n_cmp++;
      if (rv_cnt != exp_rv) begin
        n_bad++;
        $display("FAIL %s_rvalids: ack after %0d rvalids, required %0d", name, rv_cnt, exp_rv);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (cpu_read_ack !== 1'b0 || fetch_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_pulse: ack/err %b%b one cycle later, required 00", name, cpu_read_ack,
               fetch_err);
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    cpu_read_valid = 1'b0;
    cpu_read_addr  = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cpu_read_ack !== 1'b0 || fetch_err !== 1'b0 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ack/err/req %b%b%b, required 000", cpu_read_ack, fetch_err,
               mem_req);
    end
    n_cmp++;
    if (mem_addr !== '0 || cpu_read_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data: mem_addr %h data %h, required 0 and 0", mem_addr, cpu_read_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [127:0] want;
    want = 128'hA0000000_00000000_00000D00_00000011;
    start_fetch(33'd0, 1'b0, 1'b1, want);
    wait_ack("basic", 6, 4);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    start_fetch(33'd5, 1'b0, 1'b0, '0);
    wait_ack("b2b_first", 6, 4);
    start_fetch(33'd6, 1'b0, 1'b0, '0);
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_gap: mem_req %b in gap cycle, required 0", mem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: mem_req %b in idle cycle, required 0", mem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_issue: mem_req %b after idle, required 1", mem_req);
    end
    wait_ack("b2b_second", 5, 4);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [32:0] addrs [3];
    addrs    = '{33'd7, 33'd40, 33'd50};
    rand_gnt = 1'b1;
    lat      = 3;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start_fetch(addrs[i], 1'b0, 1'b0, '0);
      wait_ack("backpressure", -1, 4);
      @(negedge clk);
    end
    rand_gnt = 1'b0;
    lat      = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_timeout();
    ret_budget = 2;
    start_fetch(33'd10, 1'b1, 1'b0, '0);
    wait_ack("timeout", 18, 2);
    start_fetch(33'd11, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout_drain: mem_req %b while draining, required 0", mem_req);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 ret_budget = 1000000;
    wait_ack("timeout_next", -1, 6);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap();
    start_fetch(33'd63, 1'b0, 1'b0, '0);
    wait_ack("wrap_top", 6, 4);
    @(negedge clk);
    start_fetch(33'd64, 1'b0, 1'b0, '0);
    wait_ack("wrap_zero", 6, 4);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    start_fetch(33'd3, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    rst            = 1'b1;
    cpu_read_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_addr_q.delete();
    void'(exp_data_q.pop_front());
    void'(exp_err_q.pop_front());
    n_cmp++;
    if (cpu_read_ack !== 1'b0 || fetch_err !== 1'b0 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_ctrl: ack/err/req %b%b%b, required 000", cpu_read_ack, fetch_err,
               mem_req);
    end
    n_cmp++;
    if (mem_addr !== '0 || cpu_read_data !== '0) begin
      n_bad++;
      $display("FAIL midreset_data: mem_addr %h data %h, required 0 and 0", mem_addr,
               cpu_read_data);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (cpu_read_ack !== 1'b0) begin
        n_bad++;
        $display("FAIL midreset_noack: ack %b after reset, required 0", cpu_read_ack);
      end
    end
    start_fetch(33'd4, 1'b0, 1'b0, '0);
    wait_ack("midreset_next", 6, 4);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1);
  end

  initial begin : main
    for (int i = 0; i < 256; i++) begin
      mem[i] = {8'(i) ^ 8'h3C, 8'hA5, 8'(i), 8'h5A};
    end
    mem[0] = 32'h0000_0011;
    mem[1] = 32'h0000_0D00;
    mem[2] = 32'h0000_0000;
    mem[3] = 32'hA000_0000;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
